// File: rtl/mcu_8bit_mem_arbiter.sv
// Arbiter that shares one single-port synchronous memory between instruction fetch and load/store.
// Data has priority. A wait counter forces a fetch through, and a data-side lock holds the bus for read-modify-write.
module mcu_8bit_mem_arbiter #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 8,
    parameter int MAX_WAIT = 3
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              fetchReq,
    input  logic [ADDR_W-1:0] fetchAddr,
    output logic              fetchGnt,
    output logic              fetchRvalid,
    output logic [DATA_W-1:0] fetchRdata,
    input  logic              dataReq,
    input  logic              dataWe,
    input  logic              dataLock,
    input  logic [ADDR_W-1:0] dataAddr,
    input  logic [DATA_W-1:0] dataWdata,
    output logic              dataGnt,
    output logic              dataRvalid,
    output logic [DATA_W-1:0] dataRdata,
    output logic              memEn,
    output logic              memWe,
    output logic [ADDR_W-1:0] memAddr,
    output logic [DATA_W-1:0] memWdata,
    input  logic [DATA_W-1:0] memRdata,
    output logic [3:0]        starveCnt
);

    localparam logic [3:0] STARVE_MAX = 4'(MAX_WAIT);

    logic [3:0] starve_q, starve_d;
    logic       lock_q, lock_d;
    logic       fetch_rvalid_q, fetch_rvalid_d;
    logic       data_rvalid_q, data_rvalid_d;
    logic       fetch_win, data_win;

    // A held lock beats a saturated fetch counter; an idle lock request falls through to the normal order.
    always_comb begin
        fetch_win = 1'b0;
        data_win  = 1'b0;
        if (!Reset) begin
            if (lock_q && dataReq) begin
                data_win = 1'b1;
            end else if ((starve_q == STARVE_MAX) && fetchReq) begin
                fetch_win = 1'b1;
            end else if (dataReq) begin
                data_win = 1'b1;
            end else if (fetchReq) begin
                fetch_win = 1'b1;
            end
        end
    end

    always_comb begin
        memEn    = fetch_win | data_win;
        memWe    = data_win & dataWe;
        memAddr  = '0;
        memWdata = '0;
        if (data_win) begin
            memAddr  = dataAddr;
            memWdata = dataWdata;
        end else if (fetch_win) begin
            memAddr = fetchAddr;
        end
    end

    always_comb begin
        starve_d = '0;
        if (fetchReq && !fetch_win) begin
            starve_d = (starve_q == STARVE_MAX) ? starve_q : starve_q + 4'd1;
        end

        lock_d = lock_q;
        if (data_win) begin
            lock_d = dataLock;
        end else if (lock_q && !dataReq) begin
            lock_d = 1'b0;
        end

        fetch_rvalid_d = fetch_win;
        data_rvalid_d  = data_win & ~dataWe;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            starve_q       <= '0;
            lock_q         <= 1'b0;
            fetch_rvalid_q <= 1'b0;
            data_rvalid_q  <= 1'b0;
        end else begin
            starve_q       <= starve_d;
            lock_q         <= lock_d;
            fetch_rvalid_q <= fetch_rvalid_d;
            data_rvalid_q  <= data_rvalid_d;
        end
    end

    assign fetchGnt    = fetch_win;
    assign dataGnt     = data_win;
    assign fetchRvalid = fetch_rvalid_q;
    assign dataRvalid  = data_rvalid_q;
    assign fetchRdata  = memRdata;
    assign dataRdata   = memRdata;
    assign starveCnt   = starve_q;

endmodule

// File: tb/tb_mcu_8bit_mem_arbiter.sv
// Bench for mcu_8bit_mem_arbiter: a behavioural memory, per-requester read-data scoreboards, and one task per scenario.
module tb_mcu_8bit_mem_arbiter;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       fetchReq, dataReq, dataWe, dataLock;
    logic [7:0] fetchAddr, dataAddr, dataWdata;
    logic       fetchGnt, fetchRvalid, dataGnt, dataRvalid, memEn, memWe;
    logic [7:0] fetchRdata, dataRdata, memAddr, memWdata;
    logic [7:0] memRdata = 8'h00;
    logic [3:0] starveCnt;

    logic [7:0] mem [0:255];
    logic [7:0] fetch_q [$];
    logic [7:0] data_q  [$];
    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    mcu_8bit_mem_arbiter #(.ADDR_W(8), .DATA_W(8), .MAX_WAIT(3)) dut (
        .Clk(Clk), .Reset(Reset),
        .fetchReq(fetchReq), .fetchAddr(fetchAddr), .fetchGnt(fetchGnt),
        .fetchRvalid(fetchRvalid), .fetchRdata(fetchRdata),
        .dataReq(dataReq), .dataWe(dataWe), .dataLock(dataLock), .dataAddr(dataAddr),
        .dataWdata(dataWdata), .dataGnt(dataGnt), .dataRvalid(dataRvalid), .dataRdata(dataRdata),
        .memEn(memEn), .memWe(memWe), .memAddr(memAddr), .memWdata(memWdata),
        .memRdata(memRdata), .starveCnt(starveCnt)
    );

    // Single-port synchronous memory with one cycle of read latency.
    always @(posedge Clk) begin
        if (memEn) begin
            if (memWe) mem[memAddr] <= memWdata;
            else       memRdata <= mem[memAddr];
        end
    end

    always @(negedge Clk) begin
        if (fetchRvalid) begin
            checks++;
            if (fetch_q.size() == 0) begin
                errors++;
                $display("FAIL fetch_rvalid_unexpected got rdata=%h, required no response", fetchRdata);
            end else begin
                logic [7:0] e;
                e = fetch_q.pop_front();
                if (fetchRdata !== e) begin
                    errors++;
                    $display("FAIL fetch_rdata got %h required %h", fetchRdata, e);
                end
            end
        end
        if (dataRvalid) begin
            checks++;
            if (data_q.size() == 0) begin
                errors++;
                $display("FAIL data_rvalid_unexpected got rdata=%h, required no response", dataRdata);
            end else begin
                logic [7:0] e;
                e = data_q.pop_front();
                if (dataRdata !== e) begin
                    errors++;
                    $display("FAIL data_rdata got %h required %h", dataRdata, e);
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive_idle();
        fetchReq = 0; dataReq = 0; dataWe = 0; dataLock = 0;
        fetchAddr = 0; dataAddr = 0; dataWdata = 0;
    endtask

    task automatic test_reset();
        drive_idle();
        #1 Reset = 1'b1;
        for (int k = 0; k < 10; k++) begin
            fetchReq = 1'($urandom); dataReq = 1'($urandom); dataWe = 1'($urandom);
            dataLock = 1'($urandom); fetchAddr = 8'($urandom); dataAddr = 8'($urandom);
            dataWdata = 8'($urandom);
            @(negedge Clk);
            checks++;
            if ({fetchGnt, dataGnt, memEn, memWe, memAddr, memWdata, fetchRvalid, dataRvalid,
                 starveCnt, fetchRdata} !== '0) begin
                errors++;
                $display("FAIL reset_outputs got gnt=%b%b en=%b we=%b addr=%h wd=%h rv=%b%b starve=%0d rd=%h, required all 0",
                         fetchGnt, dataGnt, memEn, memWe, memAddr, memWdata, fetchRvalid, dataRvalid,
                         starveCnt, fetchRdata);
            end
            next_cycle();
        end
        drive_idle();
        Reset = 1'b0;
        @(negedge Clk);
        checks++;
        if (memEn !== 1'b0 || starveCnt !== 4'd0) begin
            errors++;
            $display("FAIL reset_release_idle got memEn=%b starve=%0d required 0 0", memEn, starveCnt);
        end
        next_cycle();
    endtask

    task automatic test_fetch_only();
        fetchReq = 1;
        for (int i = 0; i < 3; i++) begin
            fetchAddr = 8'(i);
            @(negedge Clk);
            checks++;
            if (fetchGnt !== 1'b1 || dataGnt !== 1'b0 || memAddr !== 8'(i) || memWe !== 1'b0) begin
                errors++;
                $display("FAIL fetch_grant got fg=%b dg=%b addr=%h we=%b required 1 0 %h 0",
                         fetchGnt, dataGnt, memAddr, memWe, 8'(i));
            end
            fetch_q.push_back(8'(i + 'h10));
            next_cycle();
        end
        drive_idle();
        repeat (2) @(negedge Clk);
        checks++;
        if (fetch_q.size() != 0) begin
            errors++;
            $display("FAIL fetch_drain got %0d pending required 0", fetch_q.size());
        end
        next_cycle();
    endtask

    task automatic test_write_read();
        dataReq = 1; dataWe = 1; dataAddr = 8'h80; dataWdata = 8'h5A;
        @(negedge Clk);
        checks++;
        if (dataGnt !== 1'b1 || memEn !== 1'b1 || memWe !== 1'b1 || memAddr !== 8'h80 || memWdata !== 8'h5A) begin
            errors++;
            $display("FAIL data_write got g=%b en=%b we=%b addr=%h wd=%h required 1 1 1 80 5a",
                     dataGnt, memEn, memWe, memAddr, memWdata);
        end
        next_cycle();
        dataWe = 0; dataWdata = 8'h00;
        @(negedge Clk);
        checks++;
        if (dataGnt !== 1'b1 || memEn !== 1'b1 || memWe !== 1'b0 || memAddr !== 8'h80) begin
            errors++;
            $display("FAIL data_read got g=%b en=%b we=%b addr=%h required 1 1 0 80",
                     dataGnt, memEn, memWe, memAddr);
        end
        data_q.push_back(8'h5A);
        next_cycle();
        drive_idle();
        repeat (2) @(negedge Clk);
        checks++;
        if (data_q.size() != 0) begin
            errors++;
            $display("FAIL write_read_drain got %0d pending required 0", data_q.size());
        end
        next_cycle();
    endtask

    task automatic test_contention();
        fetchReq = 1; fetchAddr = 8'h30; dataReq = 1; dataWe = 0; dataAddr = 8'h20;
        for (int k = 0; k < 8; k++) begin
            logic ef;
            ef = (k % 4 == 3);
            @(negedge Clk);
            checks++;
            if (fetchGnt !== ef || dataGnt !== !ef) begin
                errors++;
                $display("FAIL contention_grant cycle %0d got fg=%b dg=%b required %b %b",
                         k, fetchGnt, dataGnt, ef, !ef);
            end
            checks++;
            if (starveCnt !== 4'(k % 4)) begin
                errors++;
                $display("FAIL contention_starve cycle %0d got %0d required %0d", k, starveCnt, k % 4);
            end
            if (ef) fetch_q.push_back(8'h40);
            else    data_q.push_back(8'h30);
            next_cycle();
        end
        drive_idle();
        repeat (2) @(negedge Clk);
        checks++;
        if (fetch_q.size() != 0 || data_q.size() != 0) begin
            errors++;
            $display("FAIL contention_drain got %0d/%0d pending required 0/0", fetch_q.size(), data_q.size());
        end
        next_cycle();
    endtask

    task automatic test_lock();
        logic [3:0] exp_s [6];
        exp_s = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3};
        fetchReq = 1; fetchAddr = 8'h31;
        for (int k = 0; k < 6; k++) begin
            dataReq  = (k < 5);
            dataLock = (k < 4);
            dataWe   = (k == 4);
            dataAddr = (k < 5) ? 8'h40 : 8'h00;
            dataWdata = (k == 4) ? 8'h41 : 8'h00;
            @(negedge Clk);
            checks++;
            if (fetchGnt !== (k == 5) || dataGnt !== (k < 5)) begin
                errors++;
                $display("FAIL lock_grant step %0d got fg=%b dg=%b required %b %b",
                         k, fetchGnt, dataGnt, k == 5, k < 5);
            end
            checks++;
            if (starveCnt !== exp_s[k]) begin
                errors++;
                $display("FAIL lock_starve step %0d got %0d required %0d", k, starveCnt, exp_s[k]);
            end
            if (k < 4)  data_q.push_back(8'h50);
            if (k == 5) fetch_q.push_back(8'h41);
            next_cycle();
        end
        drive_idle();
        @(negedge Clk);
        checks++;
        if (starveCnt !== 4'd0) begin
            errors++;
            $display("FAIL lock_starve_clear got %0d required 0", starveCnt);
        end
        next_cycle();
        dataReq = 1; dataAddr = 8'h40;
        @(negedge Clk);
        data_q.push_back(8'h41);
        next_cycle();
        drive_idle();
        repeat (2) @(negedge Clk);
        checks++;
        if (fetch_q.size() != 0 || data_q.size() != 0) begin
            errors++;
            $display("FAIL lock_drain got %0d/%0d pending required 0/0", fetch_q.size(), data_q.size());
        end
        next_cycle();
    endtask

    task automatic test_abandon();
        fetchReq = 1; fetchAddr = 8'h33; dataReq = 1; dataLock = 1; dataAddr = 8'h42;
        @(negedge Clk);
        data_q.push_back(8'h52);
        next_cycle();
        dataReq = 0; dataLock = 0;
        @(negedge Clk);
        checks++;
        if (fetchGnt !== 1'b1 || dataGnt !== 1'b0 || memAddr !== 8'h33) begin
            errors++;
            $display("FAIL abandon_fetch got fg=%b dg=%b addr=%h required 1 0 33", fetchGnt, dataGnt, memAddr);
        end
        fetch_q.push_back(8'h43);
        next_cycle();
        drive_idle();
        repeat (2) @(negedge Clk);
        checks++;
        if (fetch_q.size() != 0 || data_q.size() != 0) begin
            errors++;
            $display("FAIL abandon_drain got %0d/%0d pending required 0/0", fetch_q.size(), data_q.size());
        end
        next_cycle();
    endtask

    task automatic test_reset_mid_read();
        fetchReq = 1; fetchAddr = 8'h05;
        @(negedge Clk);
        checks++;
        if (fetchGnt !== 1'b1) begin
            errors++;
            $display("FAIL midread_grant got %b required 1", fetchGnt);
        end
        fetch_q.push_back(8'h15);
        next_cycle();
        Reset = 1'b1;
        fetchReq = 0;
        fetch_q.delete();
        @(negedge Clk);
        checks++;
        if (fetchRvalid !== 1'b0 || memEn !== 1'b0) begin
            errors++;
            $display("FAIL midread_in_reset got rv=%b en=%b required 0 0", fetchRvalid, memEn);
        end
        next_cycle();
        fetchReq = 1; fetchAddr = 8'h06; dataReq = 1; dataAddr = 8'h07;
        Reset = 1'b0;
        @(negedge Clk);
        checks++;
        if (fetchRvalid !== 1'b0 || dataGnt !== 1'b1 || fetchGnt !== 1'b0 || starveCnt !== 4'd0) begin
            errors++;
            $display("FAIL midread_release got rv=%b dg=%b fg=%b starve=%0d required 0 1 0 0",
                     fetchRvalid, dataGnt, fetchGnt, starveCnt);
        end
        data_q.push_back(8'h17);
        next_cycle();
        dataReq = 0;
        @(negedge Clk);
        checks++;
        if (fetchGnt !== 1'b1 || dataRvalid !== 1'b1) begin
            errors++;
            $display("FAIL midread_overlap got fg=%b drv=%b required 1 1", fetchGnt, dataRvalid);
        end
        fetch_q.push_back(8'h16);
        next_cycle();
        drive_idle();
        repeat (2) @(negedge Clk);
        checks++;
        if (fetch_q.size() != 0 || data_q.size() != 0) begin
            errors++;
            $display("FAIL midread_drain got %0d/%0d pending required 0/0", fetch_q.size(), data_q.size());
        end
        next_cycle();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i + 'h10);
        test_reset();
        test_fetch_only();
        test_write_read();
        test_contention();
        test_lock();
        test_abandon();
        test_reset_mid_read();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mcu_8bit_mem_arbiter.md
Name: mcu_8bit_mem_arbiter

Overview:
- Shares one single-port synchronous 8-bit memory between the MCU instruction-fetch path and the load/store data path.
- Grants one requester per cycle: data priority, with a fetch anti-starvation counter and a data-side lock for atomic read-modify-write.
- Routes the 1-cycle-latency read response back to the requester that issued the read.
- Sits between the mcu_8bit core and its unified program/data memory.

Parameters:
ADDR_W, 8, address width for both requesters and memory
DATA_W, 8, data width
MAX_WAIT, 3, consecutive denied fetch cycles before fetch is forced to win (range 1..15)

Ports:
Clk  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-high reset
fetchReq  in  1  fetch read request, held until fetchGnt
fetchAddr  in  ADDR_W  fetch address
fetchGnt  out  1  combinational; request accepted this cycle
fetchRvalid  out  1  registered; fetchRdata valid this cycle
fetchRdata  out  DATA_W  equals memRdata
dataReq  in  1  data request, held until dataGnt
dataWe  in  1  1 = write, 0 = read
dataLock  in  1  keep bus after this grant
dataAddr  in  ADDR_W  data address
dataWdata  in  DATA_W  write data
dataGnt  out  1  combinational; request accepted this cycle
dataRvalid  out  1  registered; dataRdata valid this cycle
dataRdata  out  DATA_W  equals memRdata
memEn  out  1  memory access this cycle
memWe  out  1  memory write
memAddr  out  ADDR_W  memory address
memWdata  out  DATA_W  memory write data
memRdata  in  DATA_W  read data, valid 1 cycle after a read memEn
starveCnt  out  4  current fetch wait count (debug)

Behaviour:
Reset (asynchronous, Reset=1):
- Clears r_starve, r_lock, r_fetchRvalid and r_dataRvalid to 0.
- Grants, memEn, memWe, memAddr and memWdata go to 0 while Reset is high.

Grant priority, evaluated combinationally each cycle, first match wins:
1. r_lock && dataReq -> data.
2. r_starve == MAX_WAIT && fetchReq -> fetch.
3. dataReq -> data.
4. fetchReq -> fetch.
5. Otherwise, no grant.
- fetchGnt and dataGnt are never both high.

Memory command:
- memEn = fetchGnt | dataGnt.
- memWe = dataGnt & dataWe.
- memAddr and memWdata come from the winner.
- memAddr and memWdata are 0 when there is no grant.
- Fetch never writes.

Response path:
- fetchRvalid is set at the next edge after fetchGnt.
- dataRvalid is set at the next edge after dataGnt with dataWe=0.
- A data write produces no rvalid.
- Back-to-back grants are allowed every cycle, giving full throughput.
- A response and a new grant can coexist in the same cycle.

Starvation counter (r_starve):
- Increments when fetchReq && !fetchGnt, saturating at MAX_WAIT.
- Clears when fetchGnt or !fetchReq.
- Lock overrides starvation: while locked, the counter stays saturated and fetch waits.

Lock:
- r_lock is set at the edge where dataGnt && dataLock.
- r_lock is cleared at the edge where dataGnt && !dataLock, or where dataReq=0 while r_lock=1 (abandoned lock).

Boundary conditions:
- Simultaneous requests with r_starve < MAX_WAIT: data wins.
- Reset asserted while a read is in flight: the response is discarded; no rvalid in the first cycle after Reset deasserts.
- Requester inputs are sampled only in the grant cycle. Address changes while a request is pending are legal; the value present at grant is used.

Test Plan:
- Reset: Reset=1 for 100 ns with random requests -> all outputs 0, starveCnt=0; after release with no requests -> memEn=0.
- Fetch only: fetchReq=1, fetchAddr=0x00,0x01,0x02 on consecutive grants with memory preloaded mem[n]=n+0x10 -> fetchGnt every cycle; fetchRvalid one cycle later with 0x10,0x11,0x12; dataRvalid stays 0.
- Data write then read: write 0x5A to 0x80, then read 0x80 -> first cycle memWe=1, memWdata=0x5A; next cycle memWe=0; dataRvalid follows with dataRdata=0x5A.
- Contention/starvation, MAX_WAIT=3: dataReq and fetchReq held high -> grant order D,D,D,F,D,D,D,F; starveCnt steps 1,2,3,0.
- Lock: dataLock=1 on read 0x40, then write 0x41 to 0x40 with dataLock=0, fetchReq high throughout with starveCnt=3 -> both data ops granted consecutively, fetch granted the cycle after the unlocking write; starveCnt stays 3 during the lock.
- Abandoned lock / reset mid-read: lock then drop dataReq -> fetch granted the following cycle. Separately, assert Reset in the cycle after a fetch grant -> no fetchRvalid after Reset releases.
